// File: rtl/weighted_round_robin_dispatcher.sv
// rtl/weighted_round_robin_dispatcher.sv - weighted round-robin fan-out of one packet stream to N destinations
module weighted_round_robin_dispatcher #(
    parameter int REQUEST_WIDTH = 2,
    parameter int GRANT_WIDTH   = (REQUEST_WIDTH == 1) ? 1 : $clog2(REQUEST_WIDTH),
    parameter int WEIGHT_WIDTH  = 1,
    parameter logic [REQUEST_WIDTH-1:0][WEIGHT_WIDTH-1:0] WEIGHT = '1,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_last,
    output logic [REQUEST_WIDTH-1:0] o_valid,
    input  logic [REQUEST_WIDTH-1:0] i_ready,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_last,
    output logic [GRANT_WIDTH-1:0]   o_destination
);

    // True when at least one destination can ever be selected.
    function automatic bit has_nonzero_weight();
        bit found;
        found = 1'b0;
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            if (WEIGHT[i] != '0) found = 1'b1;
        end
        return found;
    endfunction

    // Lowest destination index with a nonzero weight; the pointer's home after reset.
    function automatic logic [GRANT_WIDTH-1:0] first_nonzero();
        bit found;
        int result;
        found  = 1'b0;
        result = 0;
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            if (!found && WEIGHT[i] != '0) begin
                result = i;
                found  = 1'b1;
            end
        end
        return GRANT_WIDTH'(result);
    endfunction

    // Next nonzero-weight index after cur, wrapping; returns cur if it is the only one.
    function automatic logic [GRANT_WIDTH-1:0] next_nonzero(input logic [GRANT_WIDTH-1:0] cur);
        bit found;
        int result;
        int idx;
        found  = 1'b0;
        result = int'(cur);
        for (int k = 1; k <= REQUEST_WIDTH; k++) begin
            idx = (int'(cur) + k) % REQUEST_WIDTH;
            if (!found && WEIGHT[idx] != '0) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return GRANT_WIDTH'(result);
    endfunction

    localparam logic [GRANT_WIDTH-1:0]  P0 = first_nonzero();
    localparam logic [WEIGHT_WIDTH-1:0] W0 = WEIGHT[P0];

    if (!has_nonzero_weight()) begin : g_weight_check
        $error("weighted_round_robin_dispatcher: all weights are zero");
    end

    logic                    full_q, full_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic [GRANT_WIDTH-1:0]  dest_q, dest_d;
    logic [GRANT_WIDTH-1:0]  ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic                    in_pkt_q, in_pkt_d;

    logic                    drain;
    logic                    accept;
    logic [GRANT_WIDTH-1:0]  ptr_next;

    // Handshake, output-register load/drain and weighted pointer advance.
    always_comb begin
        full_d   = full_q;
        data_d   = data_q;
        last_d   = last_q;
        dest_d   = dest_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        in_pkt_d = in_pkt_q;

        drain    = full_q && i_ready[dest_q];
        o_ready  = !full_q || drain;
        accept   = i_valid && o_ready;
        ptr_next = next_nonzero(ptr_q);

        if (accept) begin
            data_d   = i_data;
            last_d   = i_last;
            dest_d   = ptr_q;
            full_d   = 1'b1;
            in_pkt_d = !i_last;
            // Credit is consumed per whole packet, so only the final beat counts.
            if (i_last) begin
                if (credit_q > WEIGHT_WIDTH'(1)) begin
                    credit_d = credit_q - WEIGHT_WIDTH'(1);
                end else begin
                    ptr_d    = ptr_next;
                    credit_d = WEIGHT[ptr_next];
                end
            end
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q   <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            dest_q   <= '0;
            ptr_q    <= P0;
            credit_q <= W0;
            in_pkt_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            data_q   <= data_d;
            last_q   <= last_d;
            dest_q   <= dest_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            in_pkt_q <= in_pkt_d;
        end
    end

    // One-hot valid decoded from the held destination.
    always_comb begin
        o_valid = '0;
        for (int d = 0; d < REQUEST_WIDTH; d++) begin
            o_valid[d] = full_q && (dest_q == GRANT_WIDTH'(d));
        end
    end

    assign o_data        = data_q;
    assign o_last        = last_q;
    assign o_destination = dest_q;

endmodule

// File: tb/tb_weighted_round_robin_dispatcher.sv
// tb/tb_weighted_round_robin_dispatcher.sv - self-checking bench for weighted_round_robin_dispatcher
module tb_weighted_round_robin_dispatcher;

    localparam logic [2:0][1:0] W_MAIN = {2'd3, 2'd1, 2'd2};
    localparam logic [2:0][1:0] W_ZERO = {2'd0, 2'd1, 2'd0};

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic       i_last;
    logic [2:0] o_valid;
    logic [2:0] i_ready;
    logic [7:0] o_data;
    logic       o_last;
    logic [1:0] o_destination;

    logic       z_valid;
    logic       z_o_ready;
    logic [7:0] z_data;
    logic       z_last;
    logic [2:0] z_o_valid;
    logic [2:0] z_ready;
    logic [7:0] z_o_data;
    logic       z_o_last;
    logic [1:0] z_o_destination;

    always #5 i_clk = ~i_clk;

    weighted_round_robin_dispatcher #(
        .REQUEST_WIDTH(3), .WEIGHT_WIDTH(2), .WEIGHT(W_MAIN), .DATA_WIDTH(8)
    ) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last), .o_destination(o_destination)
    );

    weighted_round_robin_dispatcher #(
        .REQUEST_WIDTH(3), .WEIGHT_WIDTH(2), .WEIGHT(W_ZERO), .DATA_WIDTH(8)
    ) u_dut_zero (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(z_valid), .o_ready(z_o_ready),
        .i_data(z_data), .i_last(z_last), .o_valid(z_o_valid), .i_ready(z_ready),
        .o_data(z_o_data), .o_last(z_o_last), .o_destination(z_o_destination)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a turn schedule listing each destination weight-many times;
    // the k-th packet since reset goes to sched[k % length].
    int         sched[$];
    int         pkt_idx;
    bit         m_full;
    logic [7:0] m_data;
    bit         m_last;
    int         m_dest;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        pkt_idx = 0;
    endtask

    // Drive one cycle of main-DUT stimulus, check outputs against the model, then advance.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic [2:0] r);
        bit exp_rdy;
        bit acc;
        bit drn;
        i_valid = v;
        i_data  = d;
        i_last  = l;
        i_ready = r;
        #1;
        exp_rdy = !m_full || r[m_dest];
        chk("o_ready", 32'(o_ready), 32'(exp_rdy));
        chk("o_valid", 32'(o_valid), m_full ? 32'(1 << m_dest) : 32'd0);
        if (m_full) begin
            chk("o_data", 32'(o_data), 32'(m_data));
            chk("o_last", 32'(o_last), 32'(m_last));
            chk("o_destination", 32'(o_destination), 32'(m_dest));
        end
        acc = v && exp_rdy;
        drn = m_full && r[m_dest];
        @(posedge i_clk);
        if (acc) begin
            m_data = d;
            m_last = l;
            m_dest = sched[pkt_idx % sched.size()];
            m_full = 1'b1;
            if (l) pkt_idx++;
        end else if (drn) begin
            m_full = 1'b0;
        end
        @(negedge i_clk);
    endtask

    int tbl[12] = '{0, 0, 1, 2, 2, 2, 0, 0, 1, 2, 2, 2};

    initial begin
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < int'(W_MAIN[i]); w++) sched.push_back(i);
        model_reset();
        m_data = '0; m_last = 1'b0; m_dest = 0;

        i_rst_n = 1'b0;
        i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_ready = 3'b111;
        z_valid = 1'b0; z_data = '0; z_last = 1'b0; z_ready = 3'b111;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("reset_o_valid", 32'(o_valid), 32'd0);
        chk("reset_o_data", 32'(o_data), 32'd0);
        chk("reset_o_last", 32'(o_last), 32'd0);
        chk("reset_o_destination", 32'(o_destination), 32'd0);
        chk("reset_o_ready", 32'(o_ready), 32'd1);
        chk("reset_zero_o_valid", 32'(z_o_valid), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Weighted order: 12 single-beat packets, all ready, one per cycle.
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 8'(k + 16), 1'b1, 3'b111);
            chk("order_dest", 32'(o_destination), 32'(tbl[k]));
            chk("order_valid", 32'(o_valid), 32'(1 << tbl[k]));
        end
        cycle(1'b0, 8'h00, 1'b0, 3'b111);

        // Backpressure on destination 0 while 0xA5 is held.
        cycle(1'b1, 8'hA5, 1'b1, 3'b110);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'h5A, 1'b1, 3'b110);
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_data", 32'(o_data), 32'hA5);
        end
        cycle(1'b1, 8'h5A, 1'b1, 3'b111);
        chk("bp_next_data", 32'(o_data), 32'h5A);
        cycle(1'b0, 8'h00, 1'b0, 3'b111);

        // Multi-beat packets: 3 beats then 2 beats, each kept on one destination.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 8'(8'h30 + k), (k == 2), 3'b111);
            chk("mb3_dest", 32'(o_destination), 32'd1);
            chk("mb3_last", 32'(o_last), 32'(k == 2));
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 8'(8'h40 + k), (k == 1), 3'b111);
            chk("mb2_dest", 32'(o_destination), 32'd2);
            chk("mb2_last", 32'(o_last), 32'(k == 1));
        end
        cycle(1'b0, 8'h00, 1'b0, 3'b111);

        // Reset mid-packet to destination 1.
        i_rst_n = 1'b0;
        #1;
        model_reset();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        cycle(1'b1, 8'h50, 1'b1, 3'b111);
        cycle(1'b1, 8'h51, 1'b1, 3'b111);
        cycle(1'b1, 8'h60, 1'b0, 3'b111);
        cycle(1'b1, 8'h61, 1'b0, 3'b111);
        chk("mid_dest", 32'(o_destination), 32'd1);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 32'(o_valid), 32'd0);
        chk("mid_reset_ready", 32'(o_ready), 32'd1);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        cycle(1'b1, 8'h70, 1'b1, 3'b111);
        chk("post_reset_dest0", 32'(o_destination), 32'd0);
        cycle(1'b1, 8'h71, 1'b1, 3'b111);
        chk("post_reset_dest0_credit", 32'(o_destination), 32'd0);
        cycle(1'b1, 8'h72, 1'b1, 3'b111);
        chk("post_reset_dest1", 32'(o_destination), 32'd1);

        // Randomized traffic against the schedule model.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                  3'($urandom));
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b0, 3'b111);

        // Zero-weight skip: only destination 1 is ever selected.
        for (int k = 0; k < 6; k++) begin
            z_valid = 1'b1;
            z_data  = 8'(8'h80 + k);
            z_last  = 1'b1;
            z_ready = 3'b111;
            #1;
            chk("zero_o_ready", 32'(z_o_ready), 32'd1);
            @(posedge i_clk);
            @(negedge i_clk);
            chk("zero_dest", 32'(z_o_destination), 32'd1);
            chk("zero_valid", 32'(z_o_valid), 32'b010);
            chk("zero_data", 32'(z_o_data), 32'(8'h80 + k));
        end
        z_valid = 1'b0;
        @(negedge i_clk);
        chk("zero_drained", 32'(z_o_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
